// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use bubbles, data-memory freeze,
// branch flush (held across a freeze), saturating event counters and timeout.
module hazard_stall_unit #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF2ID_RS1,
    input  logic [4:0]       IF2ID_RS2,
    input  logic             IF2ID_UsesRS1,
    input  logic             IF2ID_UsesRS2,
    input  logic             IF2ID_IsStore,
    input  logic             ID2EX_MemRead,
    input  logic [4:0]       ID2EX_RD1,
    input  logic             EX_BranchTaken,
    input  logic             DMem_Req,
    input  logic             DMem_Ready,
    output logic             PC_Write,
    output logic             IF2ID_Write,
    output logic             ID2EX_Bubble,
    output logic             IF2ID_Flush,
    output logic             ID2EX_Flush,
    output logic             Pipe_Freeze,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    localparam int unsigned WC_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(WAIT_LIMIT);
    localparam logic [WC_W-1:0]  WC_TO   = WC_W'(WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              freeze, flush_req, load_use, timeout_hit;
    logic              stall_evt, flush_evt;

    // Hazard detection; a store's data operand is forwarded MEM-to-MEM, so it never stalls.
    always_comb begin
        freeze    = DMem_Req & ~DMem_Ready;
        flush_req = EX_BranchTaken | flush_pend_q;
        load_use  = ID2EX_MemRead & (ID2EX_RD1 != 5'd0) &
                    ((IF2ID_UsesRS1 & (ID2EX_RD1 == IF2ID_RS1)) |
                     (IF2ID_UsesRS2 & (ID2EX_RD1 == IF2ID_RS2) & ~IF2ID_IsStore));
    end

    // Next state, wait counter, pending flush and prioritized pipeline controls.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        flush_pend_d = 1'b0;
        timeout_hit  = 1'b0;
        PC_Write     = 1'b1;
        IF2ID_Write  = 1'b1;
        ID2EX_Bubble = 1'b0;
        IF2ID_Flush  = 1'b0;
        ID2EX_Flush  = 1'b0;
        Pipe_Freeze  = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;

        // wait_cnt holds the number of frozen cycles preceding the current one
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (freeze) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            ST_WAIT: begin
                if (freeze) begin
                    wait_cnt_d = (wait_cnt_q == WC_MAX) ? WC_MAX : wait_cnt_q + WC_W'(1);
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (freeze && (wait_cnt_q == WC_TO)) begin
            timeout_hit = 1'b1;
        end
        timeout_d = timeout_q | timeout_hit;

        if (freeze) begin
            Pipe_Freeze  = 1'b1;
            PC_Write     = 1'b0;
            IF2ID_Write  = 1'b0;
            flush_pend_d = flush_pend_q | EX_BranchTaken;
            stall_evt    = 1'b1;
        end else if (flush_req) begin
            IF2ID_Flush = 1'b1;
            ID2EX_Flush = 1'b1;
            flush_evt   = 1'b1;
        end else if (load_use) begin
            PC_Write     = 1'b0;
            IF2ID_Write  = 1'b0;
            ID2EX_Bubble = 1'b1;
            stall_evt    = 1'b1;
        end

        if (!rst_n) begin
            PC_Write     = 1'b0;
            IF2ID_Write  = 1'b0;
            ID2EX_Bubble = 1'b1;
            IF2ID_Flush  = 1'b0;
            ID2EX_Flush  = 1'b0;
            Pipe_Freeze  = 1'b0;
        end
    end

    // Timeout is visible in the cycle that reaches the limit, then held sticky.
    always_comb begin
        Mem_Timeout = timeout_q | (rst_n & timeout_hit);
        Stall_Count = stall_cnt_q;
        Flush_Count = flush_cnt_q;
    end

    // State, pending flush, sticky timeout and saturating counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_pend_q <= flush_pend_d;
            timeout_q    <= timeout_d;
            if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline stall and flush controller for the 5-stage core. It detects hazards that forwarding cannot resolve (load-use), freezes the pipeline on data-memory wait states, and flushes wrong-path instructions after a taken branch. A branch pulse that arrives while the pipe is frozen is held until the freeze ends. The block drives the write-enable and bubble/flush controls of PC, IF2ID and ID2EX, and a global freeze for EX2Mem and Mem2WB; it also keeps saturating stall and flush counters and a memory-timeout flag.

## Interface
- CNT_W, 32, width of the stall and flush counters
- WAIT_LIMIT, 255, consecutive frozen cycles after which Mem_Timeout is set (≥1)

- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- IF2ID_RS1, IF2ID_RS2  in  5 each  source registers of the instruction in decode
- IF2ID_UsesRS1, IF2ID_UsesRS2  in  1 each  decode instruction reads RS1 / RS2
- IF2ID_IsStore  in  1  decode instruction is a store (RS2 = store data)
- ID2EX_MemRead  in  1  instruction in EX is a load
- ID2EX_RD1  in  5  destination register of the instruction in EX
- EX_BranchTaken  in  1  single-cycle pulse: branch/jump in EX resolved taken
- DMem_Req  in  1  MEM stage has an outstanding data-memory access
- DMem_Ready  in  1  data memory completes the access this cycle
- PC_Write  out  1  PC update enable
- IF2ID_Write  out  1  IF2ID register load enable
- ID2EX_Bubble  out  1  load a NOP into ID2EX
- IF2ID_Flush, ID2EX_Flush  out  1 each  clear the register to a NOP
- Pipe_Freeze  out  1  hold EX2Mem and Mem2WB (and ID2EX) unchanged
- Mem_Timeout  out  1  sticky: a freeze reached WAIT_LIMIT cycles
- Stall_Count, Flush_Count  out  CNT_W each  saturating event counters

## Operation
- Internal signals:
  - freeze = DMem_Req & ~DMem_Ready
  - flush_req = EX_BranchTaken | flush_pend
  - load_use = ID2EX_MemRead & (ID2EX_RD1≠0) & ((IF2ID_UsesRS1 & RD1==RS1) | (IF2ID_UsesRS2 & RD1==RS2 & ~IF2ID_IsStore))
- A store whose only dependency is its store data does not stall; MEM-to-MEM forwarding covers it.
- Priority, evaluated every cycle: freeze > flush_req > load_use > normal.
- freeze:
  - Pipe_Freeze=1, PC_Write=0, IF2ID_Write=0.
  - Bubble=0 and both flushes=0.
  - An EX_BranchTaken pulse in this cycle sets flush_pend.
- flush_req (no freeze):
  - IF2ID_Flush=1, ID2EX_Flush=1, PC_Write=1 (branch target loads), IF2ID_Write=1.
  - Bubble=0; load_use is ignored.
  - flush_pend is cleared.
- load_use (no freeze, no flush):
  - PC_Write=0, IF2ID_Write=0, ID2EX_Bubble=1.
  - Stalls exactly one cycle, because the bubble removes the load dependency from the next comparison.
- normal: PC_Write=1, IF2ID_Write=1; all other controls are 0.
- FSM states:
  - RUN: RUN→WAIT when freeze.
  - WAIT: stays in WAIT while freeze; WAIT→RUN on the first cycle with ~freeze.
  - wait_cnt clears in RUN and increments each WAIT cycle, saturating at WAIT_LIMIT.
  - Mem_Timeout is set when wait_cnt reaches WAIT_LIMIT-1 while freeze is still asserted, i.e. on the WAIT_LIMIT-th consecutive frozen cycle. It stays set until reset.
  - Mem_Timeout does not alter the stall behaviour.
- Counters:
  - Stall_Count +1 on every cycle with freeze or load_use.
  - Flush_Count +1 on every cycle in which a flush is applied.
  - Both saturate at 2^CNT_W−1.

## Timing
- All controls are combinational from the inputs and registered state, and are valid in the same cycle as the inputs. There is no added latency.
- Reset (rst_n low at a posedge):
  - Clears state→RUN, flush_pend, wait_cnt, Mem_Timeout, Stall_Count and Flush_Count to 0.
  - While rst_n is low, the outputs are forced: PC_Write=0, IF2ID_Write=0, ID2EX_Bubble=1, flushes=0, Pipe_Freeze=0.
  - Reset mid-freeze or with a pending flush discards both.
- Pending flush:
  - A branch pulse during freeze is applied in the first cycle with ~freeze.
  - A second pulse while pending produces a single flush; Flush_Count +1 once.
- Simultaneous events:
  - Branch and load_use in the same unfrozen cycle: flush wins; no bubble; Stall_Count unchanged.
  - DMem_Req & DMem_Ready in the same cycle is not a freeze.
- ID2EX_RD1=0 never causes a load-use stall.

## Test plan
- Load-use: ID2EX_MemRead=1, RD1=5, RS1=5, UsesRS1=1 → one cycle with PC_Write=0, IF2ID_Write=0, Bubble=1; Stall_Count=1; next cycle (MemRead=0) normal.
- Store data: RD1=7, RS2=7, UsesRS2=1, IsStore=1, RS1≠7 → no stall. Same stimulus with IsStore=0 → Bubble=1.
- Memory wait: DMem_Req=1, Ready=0 for 3 cycles, then Ready=1 → Pipe_Freeze=1 for exactly 3 cycles; Stall_Count=3; state returns to RUN.
- Branch during freeze: EX_BranchTaken pulse in freeze cycle 2 of 4 → no flush during the freeze; both flushes=1 in the cycle after the freeze ends; Flush_Count=1.
- Timeout: WAIT_LIMIT=4, freeze held 6 cycles → Mem_Timeout rises on the 4th frozen cycle and stays 1 after the freeze ends; it clears only on rst_n=0.
- Reset mid-operation: set flush_pend during a freeze, then assert rst_n=0 for one posedge → all counters 0, no flush after release, first post-reset normal cycle PC_Write=1.
